// File: rtl/mealy_seq_pkg.sv
// mealy_seq_pkg: state encoding and reference pattern for the 1001 Mealy detector
package mealy_seq_pkg;
  typedef enum logic [1:0] {S0 = 2'b00, S1 = 2'b01, S2 = 2'b10, S3 = 2'b11} state_t;
  localparam logic [3:0] PATTERN = 4'b1001;
endpackage

// File: rtl/mealy_seq_detector.sv
// mealy_seq_detector: overlapping 1001 detector, z is combinational from state and x
module mealy_seq_detector
  import mealy_seq_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic x,
  output logic z
);
  state_t state, next;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S0;
    else state <= next;
  end
  // any 1 restarts or continues a match, so only the zero path depends on state
  always_comb begin
    next = S0;
    case (state)
      S0: next = x ? S1 : S0;
      S1: next = x ? S1 : S2;
      S2: next = x ? S1 : S3;
      S3: next = x ? S1 : S0;
      default: next = S0;
    endcase
  end
  always_comb z = (state == S3) && (x == PATTERN[0]);
endmodule

// File: tb/tb_mealy_seq_detector.sv
// tb_mealy_seq_detector: directed vectors, expected z queued by stimulus and checked by a monitor
module tb_mealy_seq_detector;
  logic clk = 1'b0, reset, x;
  logic z;
  int n_checks = 0, n_fail = 0;
  typedef struct {logic z; string name;} exp_t;
  exp_t q[$];

  mealy_seq_detector dut (.clk(clk), .reset(reset), .x(x), .z(z));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: z=%b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // x changes on negedge; z is sampled 3 units later, well before the next posedge
  always begin
    @(negedge clk);
    #3;
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      check(e.name, z, e.z);
    end
  end

  task automatic send_seq(input string name, input logic [31:0] bits, input logic [31:0] exp, input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      @(negedge clk);
      x = bits[n-1-i];
      e.z = exp[n-1-i];
      e.name = $sformatf("%s[bit%0d]", name, i + 1);
      q.push_back(e);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    x = 1'b0;
    #2;
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d queued", q.size());
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    x = 1'b0;
    #2 check("reset_x0", z, 1'b0);
    x = 1'b1;
    #2 check("reset_x1", z, 1'b0);
    #4 check("reset_x1_held", z, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    x = 1'b0;
    send_seq("post_reset", 32'b00, 32'b00, 2);
    send_seq("basic", 32'b001001, 32'b000001, 6);

    apply_reset();
    send_seq("chain", 32'b001001001010011001, 32'b000001001000010001, 18);

    apply_reset();
    send_seq("two_match", 32'b1001001, 32'b0001001, 7);

    apply_reset();
    send_seq("near_101", 32'b101001, 32'b000001, 6);
    apply_reset();
    send_seq("near_1101", 32'b1101001, 32'b0000001, 7);
    apply_reset();
    send_seq("near_10001", 32'b10001001, 32'b00000001, 8);

    apply_reset();
    send_seq("async_pre", 32'b100, 32'b000, 3);
    @(negedge clk);
    x = 1'b0;
    #1 reset = 1'b1;
    #1 check("async_rst_x0", z, 1'b0);
    x = 1'b1;
    #1 check("async_rst_x1", z, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    x = 1'b0;
    #1 check("async_released", z, 1'b0);
    send_seq("async_post", 32'b1001, 32'b0001, 4);

    apply_reset();
    send_seq("mealy_pre", 32'b100, 32'b000, 3);
    @(negedge clk);
    x = 1'b0;
    #1 check("mealy_x0", z, 1'b0);
    x = 1'b1;
    #1 check("mealy_x1", z, 1'b1);
    x = 1'b0;
    #1 check("mealy_x0_again", z, 1'b0);
    x = 1'b1;
    #1 check("mealy_x1_again", z, 1'b1);
    x = 1'b0;
    // x was 0 at the edge, so S3 falls back to S0 and a lone 1 must not detect
    send_seq("mealy_after_edge", 32'b1, 32'b0, 1);

    @(negedge clk);
    #5;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected values left unchecked, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
